track_mem_arbiter: RTL

- Shares one single-port, read-only track-map BRAM between the pixel renderer (track_view/racer_view lookups) and NUM_REQ game-logic requesters (e.g. player and opponent collision/surface lookups).
- Renderer has priority. Game requesters share the remaining idle cycles round-robin over a valid/ready handshake.
- Read data is routed back to its issuer after a fixed READ_LATENCY, using a registered tag pipeline.
- Sits in the clk_65mhz domain between the view modules, game logic and the track BRAM.

---
 rtl/track_mem_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/track_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : track_mem_arbiter
// Brief    : Shares the read-only track BRAM between the renderer (priority) and
//            NUM_REQ round-robin game requesters; optional macro STARVE_GUARD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module track_mem_arbiter #(
    parameter int ADDR_W       = 17,
    parameter int DATA_W       = 12,
    parameter int NUM_REQ      = 2,
    parameter int READ_LATENCY = 2,
    parameter int MAX_WAIT     = 8
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rend_valid,
    input  logic [ADDR_W-1:0]         rend_addr,
    output logic                      rend_data_valid,
    output logic [DATA_W-1:0]         rend_data,
    output logic                      rend_miss,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic [DATA_W-1:0]         resp_data,
    output logic                      mem_en,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic [DATA_W-1:0]         mem_rdata
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // The wait threshold only shapes logic when the starvation guard is built in.
    if (MAX_WAIT < 1) begin : g_max_wait_floor
    end

    logic [IDX_W-1:0]  r_ptr;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_tag_rend [READ_LATENCY];
    logic              r_tag_req  [READ_LATENCY];
    logic [IDX_W-1:0]  r_tag_idx  [READ_LATENCY];

    logic              w_rr_found;
    logic [IDX_W-1:0]  w_rr_idx;
    logic [IDX_W-1:0]  w_cand;
    logic              w_starve;
    logic [IDX_W-1:0]  w_starve_idx;
    logic              w_issue_rend;
    logic              w_issue_req;
    logic [IDX_W-1:0]  w_grant_idx;
    logic [ADDR_W-1:0] w_addr;

    // First valid requester strictly after the last granted one, wrapping.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_idx   = r_ptr;
        w_cand     = r_ptr;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = IDX_W'((int'(r_ptr) + k) % NUM_REQ);
            if (!w_rr_found && req_valid[w_cand]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = w_cand;
            end
        end
    end

`ifdef STARVE_GUARD_EN
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    logic [WAIT_W-1:0] r_wait [NUM_REQ];

    // Descending scan so the lowest starving index wins.
    always_comb begin
        w_starve     = 1'b0;
        w_starve_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (r_wait[i] == WAIT_W'(MAX_WAIT))) begin
                w_starve     = 1'b1;
                w_starve_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rst_in || !req_valid[i] || req_ready[i]) begin
                r_wait[i] <= '0;
            end else if (r_wait[i] != WAIT_W'(MAX_WAIT)) begin
                r_wait[i] <= r_wait[i] + 1'b1;
            end
        end
    end
`else
    assign w_starve     = 1'b0;
    assign w_starve_idx = '0;
`endif

    always_comb begin
        w_issue_rend = 1'b0;
        w_issue_req  = 1'b0;
        w_grant_idx  = r_ptr;
        rend_miss    = 1'b0;
        if (!rst_in) begin
            if (w_starve) begin
                w_issue_req = 1'b1;
                w_grant_idx = w_starve_idx;
                rend_miss   = rend_valid;
            end else if (rend_valid) begin
                w_issue_rend = 1'b1;
            end else if (w_rr_found) begin
                w_issue_req = 1'b1;
                w_grant_idx = w_rr_idx;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        w_addr    = r_mem_addr;
        if (w_issue_rend) begin
            w_addr = rend_addr;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_issue_req && (w_grant_idx == IDX_W'(i))) begin
                req_ready[i] = 1'b1;
                w_addr       = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    assign mem_en   = w_issue_rend | w_issue_req;
    assign mem_addr = w_addr;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_ptr      <= IDX_W'(NUM_REQ - 1);
            r_mem_addr <= '0;
            for (int s = 0; s < READ_LATENCY; s++) begin
                r_tag_rend[s] <= 1'b0;
                r_tag_req[s]  <= 1'b0;
                r_tag_idx[s]  <= '0;
            end
        end else begin
            if (w_issue_req) begin
                r_ptr <= w_grant_idx;
            end
            if (mem_en) begin
                r_mem_addr <= w_addr;
            end
            r_tag_rend[0] <= w_issue_rend;
            r_tag_req[0]  <= w_issue_req;
            r_tag_idx[0]  <= w_grant_idx;
            for (int s = 1; s < READ_LATENCY; s++) begin
                r_tag_rend[s] <= r_tag_rend[s-1];
                r_tag_req[s]  <= r_tag_req[s-1];
                r_tag_idx[s]  <= r_tag_idx[s-1];
            end
        end
    end

    // Strobes are masked during reset so nothing issued before it can surface.
    always_comb begin
        resp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            resp_valid[i] = !rst_in && r_tag_req[READ_LATENCY-1]
                            && (r_tag_idx[READ_LATENCY-1] == IDX_W'(i));
        end
    end

    assign rend_data_valid = r_tag_rend[READ_LATENCY-1] & ~rst_in;
    assign rend_data       = mem_rdata;
    assign resp_data       = mem_rdata;

endmodule
`default_nettype wire
